// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone classic arbiter with registered round-robin grant,
// burst-long grant hold and a stall watchdog that terminates hung transfers with err.
module wb_arbiter2 #(
    parameter int unsigned ADDR_WIDTH = 23,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    output logic                  m0_rty_o,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  m1_rty_o,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic                  s_rty_i,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    output logic [1:0]            grant_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t           state_q;
    logic [1:0]       grant_q;
    logic             last_q;
    logic [CNT_W-1:0] wd_q;
    logic [CNT_W-1:0] wd_d;
    logic             sel_stb;
    logic             term;
    logic             wd_fire;

    // Slave-side mux and termination routing, selected by the registered grant
    always_comb begin
        sel_stb  = 1'b0;
        s_cyc_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        if (grant_q[0]) begin
            sel_stb = m0_stb_i;
            s_cyc_o = m0_cyc_i;
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (grant_q[1]) begin
            sel_stb = m1_stb_i;
            s_cyc_o = m1_cyc_i;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end

        term    = s_ack_i | s_err_i | s_rty_i;
        // A slave termination in the deadline cycle beats the forced err
        wd_fire = (TIMEOUT != 0) && (grant_q != 2'b00) && sel_stb && !term
                  && (wd_q == CNT_W'(TIMEOUT));
        s_stb_o = sel_stb & ~wd_fire;

        m0_ack_o = grant_q[0] & s_ack_i;
        m0_err_o = grant_q[0] & (s_err_i | wd_fire);
        m0_rty_o = grant_q[0] & s_rty_i;
        m1_ack_o = grant_q[1] & s_ack_i;
        m1_err_o = grant_q[1] & (s_err_i | wd_fire);
        m1_rty_o = grant_q[1] & s_rty_i;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;

        if ((TIMEOUT == 0) || (grant_q == 2'b00) || !sel_stb || term || wd_fire) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + CNT_W'(1);
        end
    end

    assign grant_o = grant_q;

    // Arbitration FSM: grant held for the whole cyc burst, one idle bubble between owners
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            wd_q    <= '0;
        end else begin
            wd_q <= wd_d;
            case (state_q)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                        state_q <= OWN0;
                        grant_q <= 2'b01;
                    end else if (m1_cyc_i) begin
                        state_q <= OWN1;
                        grant_q <= 2'b10;
                    end
                end
                OWN0: begin
                    if (!m0_cyc_i) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                        last_q  <= 1'b0;
                    end
                end
                OWN1: begin
                    if (!m1_cyc_i) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                        last_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: arbitration, burst hold, watchdog, reset and routing,
// with a read-data scoreboard filled as slave data is driven and drained on master acks.
module tb_wb_arbiter2;

    localparam int unsigned AW = 23;
    localparam int unsigned DW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i;
    logic          m0_ack_o, m0_err_o, m0_rty_o;
    logic [DW-1:0] m0_dat_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i;
    logic          m1_ack_o, m1_err_o, m1_rty_o;
    logic [DW-1:0] m1_dat_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic          s_ack_i, s_err_i, s_rty_i;
    logic [DW-1:0] s_dat_i;
    logic [1:0]    grant_o;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] burst[4];

    always #5 clk_i = ~clk_i;

    wb_arbiter2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(15)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i),
        .grant_o(grant_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge (drive point)
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Let combinational outputs settle before sampling, away from the edge
    task automatic settle();
        #2;
    endtask

    task automatic terms_zero(input string tag);
        chk({tag, "_m0t"}, 32'({m0_ack_o, m0_err_o, m0_rty_o}), 32'd0);
        chk({tag, "_m1t"}, 32'({m1_ack_o, m1_err_o, m1_rty_o}), 32'd0);
    endtask

    task automatic idle_all();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0;
        s_ack_i = 0; s_err_i = 0; s_rty_i = 0; s_dat_i = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step(); step();
        rst_i = 1'b0;
    endtask

    // m0 holds stb; slave acks on stb cycle ack_at (0 = never). Checks err timing.
    task automatic wd_run(input int ack_at, input string tag);
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0;
        step();
        for (int k = 1; k <= 17; k++) begin
            s_ack_i = (k == ack_at);
            settle();
            if (ack_at == 0 && k == 16) begin
                chk({tag, "_err16"}, 32'(m0_err_o), 32'd1);
                chk({tag, "_stb16"}, 32'(s_stb_o), 32'd0);
            end else if (k == 1 || k == 15 || k == 17 || k == ack_at) begin
                chk({tag, "_noerr"}, 32'(m0_err_o), 32'd0);
                chk({tag, "_stb"}, 32'(s_stb_o), 32'd1);
                chk({tag, "_ack"}, 32'(m0_ack_o), 32'(k == ack_at));
            end
            step();
            if (k == ack_at) break;
        end
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        settle();
        chk({tag, "_drop_noerr"}, 32'(m0_err_o), 32'd0);
        step(); step();
    endtask

    initial begin
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44;
        idle_all();
        rst_i = 1'b1;
        step();
        do_reset();
        settle();
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_scyc", 32'({s_cyc_o, s_stb_o, s_we_o}), 32'd0);
        terms_zero("rst");

        // Single master write
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 23'h000002; m0_dat_i = 8'h5A;
        settle();
        chk("w_lat_scyc", 32'(s_cyc_o), 32'd0);
        step();
        s_ack_i = 1;
        settle();
        chk("w_grant", 32'(grant_o), 32'd1);
        chk("w_scyc", 32'({s_cyc_o, s_stb_o, s_we_o}), 32'h7);
        chk("w_adr", 32'(s_adr_o), 32'h2);
        chk("w_dat", 32'(s_dat_o), 32'h5A);
        chk("w_m0ack", 32'(m0_ack_o), 32'd1);
        chk("w_m1ack", 32'(m1_ack_o), 32'd0);
        step();
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        settle();
        chk("w_ack_pulse", 32'(m0_ack_o), 32'd0);
        step();
        settle();
        chk("w_grant_idle", 32'(grant_o), 32'd0);

        // Tie after reset: m0 first, one bubble, then m1, then m0 again
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        step();
        s_ack_i = 1;
        settle();
        chk("tie_g0", 32'(grant_o), 32'd1);
        chk("tie_m0ack", 32'(m0_ack_o), 32'd1);
        chk("tie_m1ack", 32'(m1_ack_o), 32'd0);
        step();
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        step();
        settle();
        chk("tie_bubble", 32'(grant_o), 32'd0);
        chk("tie_bubble_scyc", 32'(s_cyc_o), 32'd0);
        step();
        s_ack_i = 1;
        settle();
        chk("tie_g1", 32'(grant_o), 32'd2);
        chk("tie_m1ack2", 32'(m1_ack_o), 32'd1);
        chk("tie_m0ack2", 32'(m0_ack_o), 32'd0);
        step();
        m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
        step();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        step();
        settle();
        chk("tie2_g0", 32'(grant_o), 32'd1);
        m0_cyc_i = 0; m0_stb_i = 0;
        step();
        // Last owner is now m0, so m1 wins the pending tie after the bubble
        step();
        m0_cyc_i = 1; m0_stb_i = 1; m1_we_i = 0;
        step();
        settle();
        chk("burst_g1", 32'(grant_o), 32'd2);

        // Burst hold: four reads by m1 while m0 waits
        for (int i = 0; i < 4; i++) begin
            s_ack_i = 1; s_dat_i = burst[i];
            sb_q.push_back(burst[i]);
            settle();
            chk("burst_hold", 32'(grant_o), 32'd2);
            chk("burst_m0ack", 32'(m0_ack_o), 32'd0);
            if (m1_ack_o && sb_q.size() > 0) chk("burst_dat", 32'(m1_dat_o), 32'(sb_q.pop_front()));
            step();
        end
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
        settle();
        chk("burst_drop_g", 32'(grant_o), 32'd2);
        step();
        settle();
        chk("burst_bubble", 32'(grant_o), 32'd0);
        step();
        settle();
        chk("burst_m0_g", 32'(grant_o), 32'd1);
        m0_cyc_i = 0; m0_stb_i = 0;
        step(); step();

        // Watchdog: no ack, ack on cycle 15, ack on deadline cycle 16
        wd_run(0, "wd_hang");
        wd_run(15, "wd_ack15");
        wd_run(16, "wd_ack16");

        // Reset mid-transfer while m1 owns with stb high
        m1_cyc_i = 1; m1_stb_i = 1;
        step();
        settle();
        chk("mr_g1", 32'(grant_o), 32'd2);
        chk("mr_stb", 32'(s_stb_o), 32'd1);
        rst_i = 1; s_ack_i = 1; s_err_i = 1;
        step();
        settle();
        chk("mr_scyc", 32'(s_cyc_o), 32'd0);
        chk("mr_grant", 32'(grant_o), 32'd0);
        terms_zero("mr");
        rst_i = 0; s_ack_i = 0; s_err_i = 0; m0_cyc_i = 1; m0_stb_i = 1;
        step();
        settle();
        chk("mr_tie_g0", 32'(grant_o), 32'd1);
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        step(); step();

        // Retry then error routed to m1 only
        m1_cyc_i = 1; m1_stb_i = 1;
        step();
        s_rty_i = 1;
        settle();
        chk("rty_m1", 32'({m1_ack_o, m1_err_o, m1_rty_o}), 32'b001);
        chk("rty_m0", 32'({m0_ack_o, m0_err_o, m0_rty_o}), 32'd0);
        step();
        s_rty_i = 0;
        settle();
        chk("rty_pulse", 32'(m1_rty_o), 32'd0);
        step();
        s_err_i = 1;
        settle();
        chk("err_m1", 32'({m1_ack_o, m1_err_o, m1_rty_o}), 32'b010);
        chk("err_m0", 32'({m0_ack_o, m0_err_o, m0_rty_o}), 32'd0);
        step();
        s_err_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        settle();
        chk("err_pulse", 32'(m1_err_o), 32'd0);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone classic arbiter placed in front of wb2sram.
- Lets the UART bridge (master 0) and the on-chip Levenshtein engine (master 1) share the SRAM port.
- Uses registered round-robin grant, holds the grant for the whole cyc_i burst, and has a watchdog that ends a hung transfer with err.

Parameters:
ADDR_WIDTH, 23, width of the address buses.
DATA_WIDTH, 8, width of the data buses.
TIMEOUT, 15, number of cycles with stb high and no slave termination before the arbiter forces err. 0 disables the watchdog.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls
m0_adr_i  in  ADDR_WIDTH  master 0 address
m0_dat_i  in  DATA_WIDTH  master 0 write data
m0_ack_o, m0_err_o, m0_rty_o  out  1 each  master 0 terminations
m0_dat_o  out  DATA_WIDTH  master 0 read data
m1_*  same set as m0_*  master 1
s_cyc_o, s_stb_o, s_we_o  out  1 each  slave controls
s_adr_o  out  ADDR_WIDTH  slave address
s_dat_o  out  DATA_WIDTH  slave write data
s_ack_i, s_err_i, s_rty_i  in  1 each  slave terminations
s_dat_i  in  DATA_WIDTH  slave read data
grant_o  out  2  one-hot current owner: 01 = m0, 10 = m1, 00 = idle

Behaviour:
- Clock and reset: single clock clk_i. Reset is synchronous and active-high on rst_i.
- Reset values:
  - State = IDLE, grant_o = 00, last_owner = m1 (so m0 wins the first tie), watchdog count = 0.
  - All s_* outputs = 0; all m*_ack/err/rty = 0.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - Slave-side outputs are 0.
  - If exactly one mX_cyc_i is high, go to OWNX on the next edge.
  - If both are high, grant the master that is not last_owner.
  - Arbitration latency is one cycle: the slave sees cyc/stb at the earliest one cycle after the master raises cyc.
- OWNX:
  - s_cyc_o, s_stb_o, s_we_o, s_adr_o and s_dat_o come combinationally from master X.
  - s_stb_o is additionally gated low during a watchdog-err cycle.
  - s_ack_i, s_err_i and s_rty_i are routed only to master X; the other master's terminations stay 0.
  - s_dat_i is broadcast to both m*_dat_o. Only the terminations qualify the data.
  - Grant is held while mX_cyc_i stays high, so multi-beat bursts are uninterrupted.
  - When mX_cyc_i goes low: set last_owner = X and return to IDLE. Exactly one idle bubble cycle follows before any new grant.
  - The other master's request is not visible until the bubble cycle. No preemption.
- Watchdog (TIMEOUT > 0):
  - Counter width is clog2(TIMEOUT+1).
  - Increments each OWN cycle with s_stb_o = 1 and none of ack/err/rty.
  - Clears on any slave termination, when stb is low, or in IDLE.
  - When count == TIMEOUT: assert mX_err_o for exactly one cycle, hold s_stb_o = 0 in that cycle, clear the count.
  - The grant is not released; the master decides whether to drop cyc.
- Simultaneous events:
  - A slave termination in the same cycle the count reaches TIMEOUT means the slave wins: the termination is passed through, no forced err, count cleared.
  - A master dropping cyc in the same cycle as a slave ack means the ack is still routed that cycle, then the FSM goes to IDLE.
- Reset mid-transfer: all outputs return to reset values on the next edge. An outstanding slave cycle is abandoned; the slave is required to tolerate cyc dropping.
- grant_o is a registered decode of the state and is also the mux select.

Test Plan:
- Single master: m0 writes 0x5A to address 0x000002 with a 1-cycle-latency slave -> s_cyc_o rises 1 cycle after m0_cyc_i, s_adr_o = 0x000002, s_dat_o = 0x5A, m0_ack_o pulses 1 cycle, m1_ack_o stays 0, grant_o = 01 then 00.
- Tie after reset: m0 and m1 raise cyc in the same cycle -> grant_o = 01. After m0 drops cyc there is 1 IDLE cycle, then grant_o = 10. A second simultaneous request after m1 finishes -> grant_o = 01.
- Burst hold: m1 does 4 back-to-back reads of 0x11, 0x22, 0x33, 0x44 while m0 requests -> m1 receives all 4 acks with matching m1_dat_o, and m0 is not granted until 1 cycle after m1_cyc_i falls.
- Watchdog: TIMEOUT = 15, slave never acks, m0 holds stb -> m0_err_o pulses exactly on the 16th stb cycle with s_stb_o = 0 in that cycle. Slave ack on exactly cycle 15 -> ack passes and no err.
- Reset mid-transfer: assert rst_i while OWN1 has stb high -> next edge gives s_cyc_o = 0, grant_o = 00, all terminations 0. A tie immediately after reset grants m0.
- Error/retry routing: slave returns s_rty_i, then s_err_i, to m1 -> m1_rty_o and m1_err_o each pulse once, and m0_* terminations stay 0.
